// File: rtl/ctrl_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers. It issues a command to the NPU core and
// raises a level interrupt when that command completes.
module ctrl_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output logic [3*C_S_AXI_DATA_WIDTH-1:0] cmd_data,
   input  logic                            cmd_done,
   output logic                            irq
);

   localparam int unsigned NumRegs  = 4;
   localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;

   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_q [NumRegs];
   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_d [NumRegs];
   logic                            awready_q, awready_d;
   logic                            bvalid_q, bvalid_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                            cmd_valid_q, cmd_valid_d;
   logic [3*C_S_AXI_DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
   logic                            irq_q, irq_d;

   logic       wr_en, rd_en, wr_reg0, launch;
   logic [1:0] wr_idx, rd_idx;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_idx = S_AXI_AWADDR[3:2];
   assign rd_idx = S_AXI_ARADDR[3:2];

   always_comb begin
      wr_en   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
      rd_en   = arready_q & S_AXI_ARVALID;
      wr_reg0 = wr_en & (wr_idx == 2'd0);
      launch  = wr_reg0 & S_AXI_WSTRB[0] & S_AXI_WDATA[0] & ~cmd_valid_q;

      // Ready pulses for one cycle; both halves of a write must be present and no response pending.
      awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;

      bvalid_d = bvalid_q;
      if (wr_en) begin
         bvalid_d = 1'b1;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (rd_en) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[rd_idx];
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end

      for (int r = 0; r < NumRegs; r++) begin
         regs_d[r] = regs_q[r];
         for (int b = 0; b < NumBytes; b++) begin
            if (wr_en && (wr_idx == 2'(r)) && S_AXI_WSTRB[b]) begin
               regs_d[r][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
         end
      end

      // Launch is a REG0 write, so REG1..REG3 are unchanged across that edge.
      cmd_valid_d = cmd_valid_q;
      cmd_data_d  = cmd_data_q;
      if (launch) begin
         cmd_valid_d = 1'b1;
         cmd_data_d  = {regs_q[3], regs_q[2], regs_q[1]};
      end else if (cmd_valid_q && cmd_ready) begin
         cmd_valid_d = 1'b0;
      end

      // Completion wins over a clearing write in the same cycle.
      irq_d = irq_q;
      if (cmd_done && regs_q[0][1]) begin
         irq_d = 1'b1;
      end else if (wr_reg0) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int r = 0; r < NumRegs; r++) begin
            regs_q[r] <= '0;
         end
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         cmd_valid_q <= 1'b0;
         cmd_data_q  <= '0;
         irq_q       <= 1'b0;
      end else begin
         for (int r = 0; r < NumRegs; r++) begin
            regs_q[r] <= regs_d[r];
         end
         awready_q   <= awready_d;
         bvalid_q    <= bvalid_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_data_q  <= cmd_data_d;
         irq_q       <= irq_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign cmd_valid     = cmd_valid_q;
   assign cmd_data      = cmd_data_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_ctrl_axil_regs.sv
// Self-checking bench for ctrl_axil_regs: AXI-Lite register access, command launch, irq and reset,
// compared against a register/command/irq model kept in the bench.
module tb_ctrl_axil_regs;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [95:0] cmd_data;
   logic        cmd_done = 1'b0;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;
   int hs_count = 0;

   // Behavioural model
   logic [31:0] m_regs [4];
   logic        m_pend = 1'b0;
   logic [95:0] m_cmd = '0;
   logic        m_irq = 1'b0;

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) if (cmd_valid && cmd_ready) hs_count++;

   ctrl_axil_regs dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
      .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_done(cmd_done), .irq(irq)
   );

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_pend = 1'b0;
      m_cmd  = '0;
      m_irq  = 1'b0;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit hold_b, input bit done_at_hs);
      int          n;
      logic [1:0]  idx;
      logic [31:0] old0;
      idx  = addr[3:2];
      old0 = m_regs[0];
      @(negedge ACLK);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      while (!(awready && wready) && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      n_cmp++;
      if (n >= 20) begin
         n_err++;
         $display("FAIL wr_handshake addr=%h: ready never seen, need ready within 20 cycles", addr);
      end
      if (done_at_hs) cmd_done = 1'b1;
      @(negedge ACLK);
      awvalid = 1'b0; wvalid = 1'b0; cmd_done = 1'b0;
      for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      if (idx == 2'd0 && strb[0] && data[0] && !m_pend) begin
         m_pend = 1'b1;
         m_cmd  = {m_regs[3], m_regs[2], m_regs[1]};
      end
      if (done_at_hs && old0[1]) m_irq = 1'b1;
      else if (idx == 2'd0) m_irq = 1'b0;
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         n_err++;
         $display("FAIL bresp addr=%h: got bvalid=%b bresp=%b, need 1/00", addr, bvalid, bresp);
      end
      if (!hold_b) begin
         bready = 1'b1;
         @(negedge ACLK);
         bready = 1'b0;
         n_cmp++;
         if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bvalid_clear: got %b, need 0", bvalid);
         end
         if (cmd_ready) m_pend = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] data);
      int          n;
      logic [31:0] first;
      @(negedge ACLK);
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge ACLK);
         n++;
      end
      @(negedge ACLK);
      arvalid = 1'b0;
      n_cmp++;
      if (n >= 20 || rvalid !== 1'b1 || rresp !== 2'b00) begin
         n_err++;
         $display("FAIL rd_resp addr=%h: got rvalid=%b rresp=%b, need 1/00", addr, rvalid, rresp);
      end
      first = rdata;
      repeat (hold) @(negedge ACLK);
      if (hold > 0) begin
         n_cmp++;
         if (rdata !== first || rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rd_hold: got %h/%b, need %h/1", rdata, rvalid, first);
         end
      end
      data = rdata;
      rready = 1'b1;
      @(negedge ACLK);
      rready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({awready, wready, bvalid, arready, rvalid, cmd_valid, irq} !== 7'b0 ||
          rdata !== 32'h0 || cmd_data !== 96'h0 || bresp !== 2'b0 || rresp !== 2'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got ready/valid=%b rdata=%h cmd_data=%h, need all zero",
                  {awready, wready, bvalid, arready, rvalid, cmd_valid, irq}, rdata, cmd_data);
      end
      @(negedge ACLK);
      ARESETN = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] d;
      for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), (i == 2) ? 3 : 0, d);
         n_cmp++;
         if (d !== 32'(i + 1)) begin
            n_err++;
            $display("FAIL basic_read reg%0d: got %h, need %h", i, d, 32'(i + 1));
         end
      end
   endtask

   task automatic test_strobe();
      logic [31:0] d;
      axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
      axi_write(4'h5, 32'h0000_0000, 4'b0101, 1'b0, 1'b0);
      axi_read(4'h7, 0, d);
      n_cmp++;
      if (d !== 32'hFF00_FF00) begin
         n_err++;
         $display("FAIL strobe_merge: got %h, need ff00ff00", d);
      end
   endtask

   task automatic test_partial();
      int seen;
      seen = 0;
      @(negedge ACLK);
      awaddr = 4'h8; awvalid = 1'b1;
      repeat (5) begin
         @(negedge ACLK);
         if (awready || wready) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL aw_alone: got %0d ready cycles, need 0", seen);
      end
      awvalid = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] d, v;
      logic [3:0]  a, s;
      cmd_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom();
            s = 4'($urandom_range(0, 15));
            axi_write(a, v, s, 1'b0, 1'b0);
         end else begin
            axi_read(a, 0, d);
            n_cmp++;
            if (d !== m_regs[a[3:2]]) begin
               n_err++;
               $display("FAIL rand_read addr=%h: got %h, need %h", a, d, m_regs[a[3:2]]);
            end
         end
      end
      repeat (2) @(negedge ACLK);
      cmd_ready = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic test_cmd();
      int highs;
      cmd_ready = 1'b0;
      axi_write(4'h4, 32'hA, 4'hF, 1'b0, 1'b0);
      axi_write(4'h8, 32'hB, 4'hF, 1'b0, 1'b0);
      axi_write(4'hC, 32'hC, 4'hF, 1'b0, 1'b0);
      axi_write(4'h0, 32'h1, 4'hF, 1'b0, 1'b0);
      highs = 0;
      repeat (10) begin
         @(negedge ACLK);
         if (cmd_valid === 1'b1 && cmd_data === m_cmd) highs++;
      end
      n_cmp++;
      if (highs != 10 || m_cmd !== 96'h0000000C_0000000B_0000000A) begin
         n_err++;
         $display("FAIL cmd_hold: got %0d stable cycles data=%h, need 10 with %h",
                  highs, cmd_data, m_cmd);
      end
      cmd_ready = 1'b1;
      @(negedge ACLK);
      cmd_ready = 1'b0;
      m_pend = 1'b0;
      n_cmp++;
      if (cmd_valid !== 1'b0) begin
         n_err++;
         $display("FAIL cmd_drop: got cmd_valid=%b, need 0", cmd_valid);
      end
   endtask

   task automatic test_cmd_second();
      logic [95:0] exp;
      int          hs0;
      cmd_ready = 1'b0;
      for (int i = 1; i < 4; i++) axi_write(4'(i * 4), $urandom(), 4'hF, 1'b0, 1'b0);
      axi_write(4'h0, 32'h1, 4'hF, 1'b0, 1'b0);
      exp = m_cmd;
      axi_write(4'h4, ~m_regs[1], 4'hF, 1'b0, 1'b0);
      axi_write(4'h0, 32'h1, 4'hF, 1'b0, 1'b0);
      n_cmp++;
      if (cmd_valid !== 1'b1 || cmd_data !== exp || m_cmd !== exp) begin
         n_err++;
         $display("FAIL cmd_second_data: got %b/%h, need 1/%h", cmd_valid, cmd_data, exp);
      end
      hs0 = hs_count;
      cmd_ready = 1'b1;
      repeat (5) @(negedge ACLK);
      cmd_ready = 1'b0;
      m_pend = 1'b0;
      n_cmp++;
      if (hs_count - hs0 != 1) begin
         n_err++;
         $display("FAIL cmd_second_count: got %0d handshakes, need 1", hs_count - hs0);
      end
   endtask

   task automatic pulse_done();
      @(negedge ACLK);
      cmd_done = 1'b1;
      @(negedge ACLK);
      cmd_done = 1'b0;
      if (m_regs[0][1]) m_irq = 1'b1;
   endtask

   task automatic test_irq();
      cmd_ready = 1'b1;
      axi_write(4'h0, 32'h3, 4'hF, 1'b0, 1'b0);
      pulse_done();
      n_cmp++;
      if (irq !== m_irq || m_irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_set: got %b, need 1", irq);
      end
      axi_write(4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
      n_cmp++;
      if (irq !== m_irq) begin
         n_err++;
         $display("FAIL irq_clear: got %b, need %b", irq, m_irq);
      end
      axi_write(4'h0, 32'h1, 4'hF, 1'b0, 1'b0);
      pulse_done();
      repeat (2) @(negedge ACLK);
      n_cmp++;
      if (irq !== m_irq) begin
         n_err++;
         $display("FAIL irq_disabled: got %b, need %b", irq, m_irq);
      end
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, 1'b0);
      pulse_done();
      axi_write(4'h0, 32'h2, 4'hF, 1'b0, 1'b1);
      n_cmp++;
      if (irq !== m_irq || m_irq !== 1'b1) begin
         n_err++;
         $display("FAIL irq_simul: got %b, need 1", irq);
      end
      axi_write(4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
      cmd_ready = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic test_reset_midflight();
      logic [31:0] d;
      int          bad;
      cmd_ready = 1'b0;
      axi_write(4'h0, 32'h1, 4'hF, 1'b1, 1'b0);
      #2;
      ARESETN = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (bvalid !== 1'b0 || cmd_valid !== 1'b0 || irq !== 1'b0) begin
         n_err++;
         $display("FAIL rst_async: got bvalid=%b cmd_valid=%b irq=%b, need 0/0/0",
                  bvalid, cmd_valid, irq);
      end
      @(negedge ACLK);
      ARESETN = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge ACLK);
         if (bvalid || cmd_valid || rvalid) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL rst_reissue: got %0d cycles with a valid, need 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i * 4), 0, d);
         n_cmp++;
         if (d !== m_regs[i]) begin
            n_err++;
            $display("FAIL rst_regs reg%0d: got %h, need %h", i, d, m_regs[i]);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_strobe();
      test_partial();
      test_random();
      test_cmd();
      test_cmd_second();
      test_irq();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ctrl_axil_regs.md
CTRL_AXIL_REGS -- requirements
Module: ctrl_axil_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, default 4, byte address width; 4 registers at 0x0, 0x4, 0x8, 0xC.
REQ-003 ACLK  in  1  single clock for all logic.
REQ-004 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 S_AXI_AWADDR  in  4, S_AXI_AWPROT  in  3 (ignored), S_AXI_AWVALID  in  1, S_AXI_AWREADY  out  1: write address channel.
REQ-006 S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4, S_AXI_WVALID  in  1, S_AXI_WREADY  out  1: write data channel.
REQ-007 S_AXI_BRESP  out  2, S_AXI_BVALID  out  1, S_AXI_BREADY  in  1: write response channel.
REQ-008 S_AXI_ARADDR  in  4, S_AXI_ARPROT  in  3 (ignored), S_AXI_ARVALID  in  1, S_AXI_ARREADY  out  1: read address channel.
REQ-009 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID  out  1, S_AXI_RREADY  in  1: read data channel.
REQ-010 cmd_valid  out  1, cmd_ready  in  1, cmd_data  out  96: command to NPU core, cmd_data = {REG3, REG2, REG1}.
REQ-011 cmd_done  in  1: single-cycle pulse from NPU core on command completion.
REQ-012 irq  out  1: level interrupt to the processor.

Function
REQ-013 REG0..REG3 are 32-bit read/write registers; a read returns exactly the last value written (REG0 included), so write-then-read of 1,2,3,4 at 0x0..0xC returns 1,2,3,4.
REQ-014 Write: S_AXI_AWREADY and S_AXI_WREADY assert together for exactly one cycle when AWVALID and WVALID are both high and BVALID is low; register update occurs on that cycle's edge.
REQ-015 Write byte lanes honour S_AXI_WSTRB; a lane with strobe 0 keeps its old value.
REQ-016 S_AXI_BVALID asserts the cycle after the write handshake and holds until BREADY; BRESP is always 2'b00.
REQ-017 No new write is accepted while BVALID is high; AW or W arriving alone is not accepted until its partner arrives.
REQ-018 Read: S_AXI_ARREADY asserts for one cycle when ARVALID is high and RVALID is low; RVALID and RDATA are registered the following cycle and held stable until RREADY; RRESP is always 2'b00.
REQ-019 Read and write channels operate independently; a read of a register written in the same cycle returns the pre-write value.
REQ-020 Address decode uses AWADDR[3:2] / ARADDR[3:2]; bits [1:0] are ignored.
REQ-021 Command launch: a completed write to 0x0 with WDATA[0]=1 (lane 0 strobed) while cmd_valid is low raises cmd_valid on the next cycle; cmd_data is captured from REG1..REG3 as they stand after that write edge.
REQ-022 cmd_valid and cmd_data hold stable until the cycle where cmd_valid and cmd_ready are both high; cmd_valid deasserts the next cycle.
REQ-023 A launch write while cmd_valid is high updates REG0 but does not issue a second command, and does not alter the pending cmd_data.
REQ-024 irq sets on the cycle after cmd_done when REG0[1]=1, stays high, and clears on any completed write to 0x0; a simultaneous cmd_done and write to 0x0 leaves irq set.
REQ-025 cmd_done while REG0[1]=0 has no effect.

Reset
REQ-026 ARESETN low clears immediately: REG0..REG3=0, all READY/VALID outputs=0, RDATA=0, BRESP=RRESP=0, cmd_valid=0, cmd_data=0, irq=0.
REQ-027 Reset during an outstanding command or response abandons it; after ARESETN rises no command, BVALID or RVALID is re-issued.
REQ-028 The first handshake is accepted no earlier than the first ACLK rising edge after ARESETN deassertion.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1,0x2,0x3,0x4, all BRESP/RRESP OKAY.
REQ-030 Write REG1=0xA, REG2=0xB, REG3=0xC, then write 0x1 to 0x0 with cmd_ready=0 for 10 cycles -> cmd_valid held high 10 cycles, cmd_data=0x0000000C_0000000B_0000000A, drops one cycle after cmd_ready=1.
REQ-031 Write 0xFFFFFFFF to 0x4, then write 0x00000000 with WSTRB=4'b0101 -> read 0x4 returns 0xFF00FF00.
REQ-032 Write 0x3 to 0x0, pulse cmd_done -> irq=1; write 0x0 to 0x0 -> irq=0; repeat with REG0=0x1 -> irq stays 0.
REQ-033 Second launch write while cmd_valid high with cmd_ready=0 -> exactly one cmd_valid/cmd_ready handshake observed, original cmd_data preserved.
REQ-034 Assert ARESETN low while BVALID and cmd_valid are high -> both drop immediately, all registers read 0 after release.
